// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: bundles the producer-side byte handshake and the
// transmitter-side FIFO/config signals of the shared UART TX scheduler.
// slave  : the scheduler's view.
// master : the surrounding logic's view (producers, control, transmitter).
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 cfg_req_i;
  logic                 cfg_busy_o;
  logic                 cfg_done_o;
  logic [7:0]           tx_data_o;
  logic                 tx_fifo_write_o;
  logic                 tx_fifo_full_i;
  logic                 tx_fifo_empty_i;
  logic                 tx_done_i;
  logic                 req_done_i;
  logic                 config_req_mst_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, cfg_req_i,
           tx_fifo_full_i, tx_fifo_empty_i, tx_done_i, req_done_i,
    output req_ready_o, cfg_busy_o, cfg_done_o, tx_data_o,
           tx_fifo_write_o, config_req_mst_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, cfg_req_i,
           tx_fifo_full_i, tx_fifo_empty_i, tx_done_i, req_done_i,
    input  req_ready_o, cfg_busy_o, cfg_done_o, tx_data_o,
           tx_fifo_write_o, config_req_mst_o
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter's FIFO write
// port among NUM_REQ byte producers, with a drain-then-configure sequence
// for configuration requests. Grants are combinational (zero latency).
// Optional feature macro: UART_TX_PACKET_LOCK_EN -- keeps the grant on one
// requester until it transfers a byte flagged with req_last_i.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  uart_tx_scheduler_if.slave  bus
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CFG   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic                 outstanding_q;
  logic                 cfg_req_mst_q;
  logic                 cfg_done_q;
  logic                 set_cfg, clr_cfg;

  logic                 rr_vld;
  logic [PTR_W-1:0]     rr_idx;
  logic [PTR_W-1:0]     cand;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   ready;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_write;
  logic                 lock_active;

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!rr_vld && bus.req_valid_i[cand]) begin
        rr_vld = 1'b1;
        rr_idx = cand;
      end
    end
  end

`ifdef UART_TX_PACKET_LOCK_EN
  logic             locked_q;
  logic [PTR_W-1:0] lock_idx_q;

  assign lock_active = locked_q;

  // Grant: only in ARB with FIFO room; a locked packet owns the port.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state_q == ST_ARB && !bus.tx_fifo_full_i) begin
      if (locked_q) begin
        grant_vld = bus.req_valid_i[lock_idx_q];
        grant_idx = lock_idx_q;
      end else begin
        grant_vld = rr_vld;
        grant_idx = rr_idx;
      end
    end
  end

  // Packet lock: engage after a non-last byte, release after a last byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else if (tx_write) begin
      locked_q   <= !bus.req_last_i[grant_idx];
      lock_idx_q <= grant_idx;
    end
  end
`else
  logic unused_last;

  assign lock_active = 1'b0;
  assign unused_last = ^bus.req_last_i;

  // Grant: only in ARB with FIFO room, plain per-byte round robin.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state_q == ST_ARB && !bus.tx_fifo_full_i) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end
  end
`endif

  // One-hot ready and the granted byte steered to the transmitter FIFO.
  always_comb begin
    ready   = '0;
    tx_data = '0;
    if (grant_vld) begin
      ready[grant_idx] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i] && bus.req_valid_i[i]) begin
        tx_data = bus.req_data_i[8*i +: 8];
      end
    end
  end

  assign tx_write = |(bus.req_valid_i & ready);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; config request is only sampled in ARB and only unlocked.
  always_comb begin
    state_d = state_q;
    set_cfg = 1'b0;
    clr_cfg = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (bus.cfg_req_i && !lock_active) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.tx_fifo_empty_i && !outstanding_q) begin
          state_d = ST_CFG;
          set_cfg = 1'b1;
        end
      end
      ST_CFG: begin
        if (bus.req_done_i) begin
          state_d = ST_ARB;
          clr_cfg = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Round-robin pointer follows the last granted requester.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
    end else if (tx_write) begin
      rr_ptr_q <= grant_idx;
    end
  end

  // In-flight frame tracker; a new write beats a same-cycle end-of-frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      outstanding_q <= 1'b0;
    end else if (tx_write) begin
      outstanding_q <= 1'b1;
    end else if (bus.tx_done_i && bus.tx_fifo_empty_i) begin
      outstanding_q <= 1'b0;
    end
  end

  // Registered config request to the transmitter and completion pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_req_mst_q <= 1'b0;
      cfg_done_q    <= 1'b0;
    end else begin
      cfg_done_q <= clr_cfg;
      if (set_cfg) begin
        cfg_req_mst_q <= 1'b1;
      end else if (clr_cfg) begin
        cfg_req_mst_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o      = ready;
  assign bus.tx_data_o        = tx_data;
  assign bus.tx_fifo_write_o  = tx_write;
  assign bus.cfg_busy_o       = (state_q != ST_ARB);
  assign bus.cfg_done_o       = cfg_done_q;
  assign bus.config_req_mst_o = cfg_req_mst_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed stimulus for the UART TX scheduler with a
// queue-based scoreboard; a negedge monitor pops one expected (requester,
// byte) entry per FIFO write. Lock test runs when UART_TX_PACKET_LOCK_EN set.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int idx, input logic [7:0] data);
    bus.req_data_i[8*idx +: 8] = data;
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_fifo_full_i) begin
        check("ready_while_full", 32'(bus.req_ready_o), 32'd0);
      end
      if (bus.tx_fifo_write_o) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: data 0x%0h ready 0x%0h, expected no write at %0t",
                   bus.tx_data_o, bus.req_ready_o, $time);
        end else begin
          exp_t e;
          int   gi;
          e  = exp_q.pop_front();
          gi = -1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready_o[i]) gi = i;
          end
          check("grant_idx", 32'(gi), 32'(e.idx));
          check("tx_data", 32'(bus.tx_data_o), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_valid_i     = '0;
    bus.req_data_i      = '0;
    bus.req_last_i      = '0;
    bus.cfg_req_i       = 1'b0;
    bus.tx_fifo_full_i  = 1'b0;
    bus.tx_fifo_empty_i = 1'b1;
    bus.tx_done_i       = 1'b0;
    bus.req_done_i      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_write", 32'(bus.tx_fifo_write_o), 32'd0);
    check("rst_busy", 32'(bus.cfg_busy_o), 32'd0);
    check("rst_mst", 32'(bus.config_req_mst_o), 32'd0);
    check("rst_done", 32'(bus.cfg_done_o), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Test 1: all valid after reset -> 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) set_byte(i, 8'h10 + 8'(i));
    bus.req_valid_i = 4'hF;
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
    repeat (5) cyc();
    bus.req_valid_i = '0;

    // Test 2: FIFO full holds off req 2, then written the cycle full drops
    bus.tx_fifo_full_i = 1'b1;
    set_byte(2, 8'hA2);
    bus.req_valid_i = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_ready", 32'(bus.req_ready_o), 32'd0);
      check("full_write", 32'(bus.tx_fifo_write_o), 32'd0);
      cyc();
    end
    bus.tx_fifo_full_i = 1'b0;
    push(2, 8'hA2);
    cyc();
    bus.req_valid_i = '0;

    // Test 3: 3 bytes queued, then config sequence waits for empty + tx_done
    bus.tx_fifo_empty_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    set_byte(1, 8'h31); push(1, 8'h31); cyc();
    set_byte(1, 8'h32); push(1, 8'h32); cyc();
    set_byte(1, 8'h33); push(1, 8'h33); cyc();
    bus.req_valid_i = '0;
    bus.cfg_req_i = 1'b1;
    cyc();
    set_byte(0, 8'h40);
    bus.req_valid_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drain_ready", 32'(bus.req_ready_o), 32'd0);
      check("drain_busy", 32'(bus.cfg_busy_o), 32'd1);
      check("drain_mst_fifo", 32'(bus.config_req_mst_o), 32'd0);
      cyc();
    end
    bus.tx_fifo_empty_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_mst_outst", 32'(bus.config_req_mst_o), 32'd0);
      cyc();
    end
    bus.tx_done_i = 1'b1;
    cyc();
    bus.tx_done_i = 1'b0;
    bus.req_valid_i = '0;
    @(negedge clk);
    check("t3_mst_pre", 32'(bus.config_req_mst_o), 32'd0);
    check("t3_busy_pre", 32'(bus.cfg_busy_o), 32'd1);
    cyc();
    @(negedge clk);
    check("t3_mst_rise", 32'(bus.config_req_mst_o), 32'd1);
    check("t3_done_low", 32'(bus.cfg_done_o), 32'd0);
    cyc();
    @(negedge clk);
    check("t3_mst_hold", 32'(bus.config_req_mst_o), 32'd1);
    bus.req_done_i = 1'b1;
    bus.cfg_req_i  = 1'b0;
    cyc();
    bus.req_done_i = 1'b0;
    @(negedge clk);
    check("t3_mst_fall", 32'(bus.config_req_mst_o), 32'd0);
    check("t3_done_pulse", 32'(bus.cfg_done_o), 32'd1);
    check("t3_busy_post", 32'(bus.cfg_busy_o), 32'd0);
    cyc();
    @(negedge clk);
    check("t3_done_end", 32'(bus.cfg_done_o), 32'd0);

    // Test 4: idle config request, DRAIN->CFG in one cycle
    bus.cfg_req_i = 1'b1;
    cyc();
    @(negedge clk);
    check("t4_busy", 32'(bus.cfg_busy_o), 32'd1);
    check("t4_mst_low", 32'(bus.config_req_mst_o), 32'd0);
    cyc();
    @(negedge clk);
    check("t4_mst_high", 32'(bus.config_req_mst_o), 32'd1);
    bus.cfg_req_i  = 1'b0;
    bus.req_done_i = 1'b1;
    cyc();
    bus.req_done_i = 1'b0;
    @(negedge clk);
    check("t4_done", 32'(bus.cfg_done_o), 32'd1);
    check("t4_mst_fall", 32'(bus.config_req_mst_o), 32'd0);
    cyc();

    // Test 5: tx_done in the same cycle as a write keeps outstanding set
    set_byte(3, 8'hD3);
    bus.req_valid_i = 4'b1000;
    bus.tx_done_i   = 1'b1;
    bus.cfg_req_i   = 1'b1;
    push(3, 8'hD3);
    cyc();
    bus.req_valid_i = '0;
    bus.tx_done_i   = 1'b0;
    bus.cfg_req_i   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_mst_low", 32'(bus.config_req_mst_o), 32'd0);
      check("t5_busy", 32'(bus.cfg_busy_o), 32'd1);
      cyc();
    end
    bus.tx_done_i = 1'b1;
    cyc();
    bus.tx_done_i = 1'b0;
    cyc();
    @(negedge clk);
    check("t5_mst_high", 32'(bus.config_req_mst_o), 32'd1);
    bus.req_done_i = 1'b1;
    cyc();
    bus.req_done_i = 1'b0;
    @(negedge clk);
    check("t5_done", 32'(bus.cfg_done_o), 32'd1);
    cyc();

    // Test 6: rr_ptr=3 with requesters 0 and 2 valid -> 0,2,0
    set_byte(0, 8'h60);
    set_byte(2, 8'h62);
    bus.req_valid_i = 4'b0101;
    push(0, 8'h60); push(2, 8'h62); push(0, 8'h60);
    repeat (3) cyc();
    bus.req_valid_i = '0;

`ifdef UART_TX_PACKET_LOCK_EN
    // Test 7: packet lock on req 1, config deferred until packet ends
    set_byte(0, 8'h70);
    set_byte(1, 8'h81);
    bus.req_last_i  = 4'b0000;
    bus.req_valid_i = 4'b0011;
    push(1, 8'h81);
    cyc();
    set_byte(1, 8'h82);
    bus.cfg_req_i = 1'b1;
    push(1, 8'h82);
    @(negedge clk);
    check("t7_busy_b2", 32'(bus.cfg_busy_o), 32'd0);
    cyc();
    set_byte(1, 8'h83);
    bus.req_last_i = 4'b0010;
    push(1, 8'h83);
    @(negedge clk);
    check("t7_busy_b3", 32'(bus.cfg_busy_o), 32'd0);
    cyc();
    bus.req_last_i  = 4'b0000;
    bus.req_valid_i = 4'b0001;
    push(0, 8'h70);
    @(negedge clk);
    check("t7_busy_b4", 32'(bus.cfg_busy_o), 32'd0);
    cyc();
    bus.req_valid_i = '0;
    bus.cfg_req_i   = 1'b0;
    @(negedge clk);
    check("t7_busy_drain", 32'(bus.cfg_busy_o), 32'd1);
    bus.tx_done_i = 1'b1;
    cyc();
    bus.tx_done_i = 1'b0;
    cyc();
    @(negedge clk);
    check("t7_mst_high", 32'(bus.config_req_mst_o), 32'd1);
    bus.req_done_i = 1'b1;
    cyc();
    bus.req_done_i = 1'b0;
    @(negedge clk);
    check("t7_done", 32'(bus.cfg_done_o), 32'd1);
    cyc();
`endif

    // Test 8: asynchronous reset while config request is up
    bus.cfg_req_i = 1'b1;
    bus.tx_done_i = 1'b1;
    cyc();
    bus.cfg_req_i = 1'b0;
    bus.tx_done_i = 1'b0;
    cyc();
    @(negedge clk);
    check("t8_mst_high", 32'(bus.config_req_mst_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_mst_async", 32'(bus.config_req_mst_o), 32'd0);
    check("t8_busy_async", 32'(bus.cfg_busy_o), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
